fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction cache.
- Owns the program counter and drives the cache lookup address. Consumes the 32-bit instruction word and stall flag returned by the cache.
- Buffers fetched instructions in a 2-entry queue toward decode, with valid/ready backpressure.
- Handles control-flow redirects from execute by flushing the queue and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_1000, PC value loaded on reset.
- DEPTH, 2, queue entries toward decode. Fixed at 2; other values are unsupported.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- icache_addr  out  32  fetch address to the instruction cache; equals pc_q combinationally.
- icache_data  in  32  instruction word returned by the cache for icache_addr, same cycle.
- icache_stall  in  1  cache cannot deliver this cycle; icache_data is invalid.
- redirect_valid  in  1  control-flow redirect from execute (branch, jump or trap).
- redirect_pc  in  32  redirect target; low 2 bits are ignored.
- dec_valid  out  1  head queue entry is valid.
- dec_ready  in  1  decode accepts the head entry this cycle.
- dec_instr  out  32  instruction word of the head entry.
- dec_pc  out  32  PC of the head entry.

Behaviour:
- Reset (asynchronous, immediate):
  - pc_q = RESET_PC.
  - Queue count = 0, read/write pointers = 0, all entry storage = 0.
  - dec_valid = 0, dec_instr = 0, dec_pc = 0.
  - icache_addr = RESET_PC.
  - Reset asserted mid-operation discards all queued entries; no entry survives.
- Definitions, all evaluated on registered state at the start of the cycle:
  - fire = !icache_stall && count < 2 && !redirect_valid.
  - pop = dec_valid && dec_ready && !redirect_valid.
- On fire:
  - Push {pc_q, icache_data} at the write pointer.
  - pc_q <= pc_q + 32'd4, modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- On icache_stall=1:
  - No push; pc_q holds; icache_addr stays stable until the cache delivers.
- Queue full (count==2):
  - No fire, even if a pop occurs in the same cycle.
  - Draining from full therefore costs one fetch bubble. This is intended; it keeps the full condition registered-only.
- Push and pop in the same cycle: count is unchanged; both pointers advance.
- count==0: dec_valid=0. dec_instr/dec_pc hold the last head contents and must not be relied upon.
- Redirect, highest priority:
  - On a redirect_valid cycle, no push and no pop.
  - Queue is flushed (count <= 0, pointers <= 0).
  - pc_q <= {redirect_pc[31:2], 2'b00}.
  - Next cycle: dec_valid=0 and icache_addr = the redirect target.
  - Redirect asserted together with icache_stall behaves identically.
  - Back-to-back redirects: the last one wins.
- Latency:
  - An instruction fetched at cycle N (fire) appears on dec_* at cycle N+1.
  - Sustained throughput is 1 instr/cycle when icache_stall=0 and dec_ready=1 continuously.
- dec_valid, dec_instr and dec_pc are driven from registered state only; there is no combinational path from icache_data to the dec_* outputs.
- Decode backpressure: while dec_valid=1 and dec_ready=0, the head entry (dec_instr, dec_pc) must remain stable until popped or flushed.

Decomposition:
- cpu_pkg holds:
  - localparam RESET_PC_DEFAULT = 32'h0000_1000.
  - localparam INSTR_BYTES = 4.
  - typedef struct packed { logic [31:0] pc; logic [31:0] instr; } fetch_entry_t.
- One sub-module: fetch_skid_fifo.
  - 2-entry FIFO of fetch_entry_t with push, pop, flush, count, full and empty.
  - Asynchronous reset.
  - flush has priority over push and pop.
- fetch_stage itself holds only pc_q and the fire/redirect logic.

Test Plan:
- Reset with RESET_PC=32'h1000, icache_stall=0, dec_ready=1 -> icache_addr sequence 1000, 1004, 1008; dec_pc of 1000 appears one cycle after its fire; dec_valid held 1 thereafter, one instr/cycle.
- dec_ready=0 for 5 cycles -> two entries queued (1000, 1004); icache_addr holds 1008; dec_instr/dec_pc stable; on release, entries pop in order, one bubble, then streaming resumes at 1008.
- icache_stall=1 for 3 cycles at pc 2000 -> no pushes; icache_addr holds 2000; queue drains to empty and dec_valid=0; when the stall drops, the 2000 entry is delivered next cycle.
- redirect_valid with redirect_pc=32'h3003 while queue is full -> next cycle: dec_valid=0, icache_addr=3000, count=0; the first entry delivered has dec_pc=3000.
- Redirect to 32'hFFFF_FFFC with free-run -> dec_pc sequence FFFFFFFC then 00000000.
- Assert reset mid-stream with 2 entries queued -> dec_valid=0 immediately (asynchronously); after release, icache_addr=RESET_PC and no stale entry appears.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions.
//   RESET_PC_DEFAULT : PC loaded on reset unless overridden
//   INSTR_BYTES      : byte stride between sequential instructions
//   fetch_entry_t    : {pc, instr} pair carried toward decode
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;
  localparam int unsigned INSTR_BYTES      = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of fetch entries between the fetch stage and decode.
// Ports:
//   clock, reset  : clock, asynchronous active-high reset
//   push          : write push_entry at the write pointer (ignored when full)
//   push_entry    : entry to write
//   pop           : retire the head entry (ignored when empty)
//   flush         : discard all entries; overrides push and pop
//   head          : entry at the read pointer (registered storage)
//   count         : number of valid entries
//   full, empty   : count == DEPTH, count == 0
module fetch_skid_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign full    = (count == 2'(DEPTH));
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the I-cache lookup address,
// and queues fetched instructions toward decode with valid/ready handshake.
// Redirects from execute flush the queue and reload the PC.
// Ports:
//   clock, reset    : clock, asynchronous active-high reset
//   icache_addr     : fetch address (= pc_q)
//   icache_data     : instruction word for icache_addr, same cycle
//   icache_stall    : cache cannot deliver this cycle
//   redirect_valid  : control-flow redirect (highest priority)
//   redirect_pc     : redirect target, low 2 bits ignored
//   dec_valid       : head entry valid
//   dec_ready       : decode accepts head entry
//   dec_instr       : head instruction word
//   dec_pc          : head PC
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] icache_addr,
  input  logic [31:0] icache_data,
  input  logic        icache_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  logic [31:0]  pc_q;
  logic         fire;
  logic         pop;
  logic         q_full;
  logic         q_empty;
  logic [1:0]   q_count;
  fetch_entry_t q_head;
  fetch_entry_t new_entry;

  // Full is sampled from registered count, so a pop in the same cycle does
  // not free a slot for this cycle's fetch (one bubble when draining from full).
  assign fire      = !icache_stall && !q_full && !redirect_valid;
  assign pop       = dec_valid && dec_ready && !redirect_valid;
  assign new_entry = '{pc: pc_q, instr: icache_data};

  assign icache_addr = pc_q;
  assign dec_valid   = !q_empty;
  assign dec_instr   = q_head.instr;
  assign dec_pc      = q_head.pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[31:2], 2'b00};
    end else if (fire) begin
      pc_q <= pc_q + 32'(INSTR_BYTES);
    end
  end

  fetch_skid_fifo #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (fire),
    .push_entry (new_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (q_head),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] DATA_KEY = 32'h5A5A_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] icache_addr;
  logic [31:0] icache_data;
  logic        icache_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Cache model: each word is its address XORed with a key.
  assign icache_data = icache_addr ^ DATA_KEY;

  fetch_stage #(
    .RESET_PC (32'h0000_1000),
    .DEPTH    (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .icache_addr    (icache_addr),
    .icache_data    (icache_data),
    .icache_stall   (icache_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(dec_valid), 32'd1);
    chk({tag, "_pc"}, dec_pc, pc);
    chk({tag, "_instr"}, dec_instr, pc ^ DATA_KEY);
  endtask

  initial begin
    reset          = 1'b1;
    icache_stall   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b1;
    #2;
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_instr", dec_instr, 32'd0);
    chk("rst_pc", dec_pc, 32'd0);
    chk("rst_addr", icache_addr, 32'h0000_1000);
    #10;
    reset = 1'b0;
    chk("post_rst_addr", icache_addr, 32'h0000_1000);

    // Free run: one instruction per cycle, one cycle latency.
    step();
    chk_head("run0", 32'h0000_1000);
    chk("run0_addr", icache_addr, 32'h0000_1004);
    step();
    chk_head("run1", 32'h0000_1004);
    chk("run1_addr", icache_addr, 32'h0000_1008);
    step();
    chk_head("run2", 32'h0000_1008);
    chk("run2_addr", icache_addr, 32'h0000_100C);

    // Backpressure for 5 cycles: queue fills with 1008, 100C; fetch holds at 1010.
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_head("bp_hold", 32'h0000_1008);
      chk("bp_addr", icache_addr, 32'h0000_1010);
    end
    dec_ready = 1'b1;
    step();
    chk_head("drain0", 32'h0000_100C);
    chk("drain0_addr", icache_addr, 32'h0000_1010);
    step();
    chk_head("drain1", 32'h0000_1010);
    chk("drain1_addr", icache_addr, 32'h0000_1014);
    step();
    chk_head("drain2", 32'h0000_1014);

    // Redirect to 2000, fetch one, then stall at 2004 for 3 cycles.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    step();
    redirect_valid = 1'b0;
    chk("redir2k_valid", 32'(dec_valid), 32'd0);
    chk("redir2k_addr", icache_addr, 32'h0000_2000);
    step();
    chk_head("f2k", 32'h0000_2000);
    icache_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 32'(dec_valid), 32'd0);
      chk("stall_addr", icache_addr, 32'h0000_2004);
    end
    icache_stall = 1'b0;
    step();
    chk_head("unstall", 32'h0000_2004);

    // Fill the queue, then redirect to 3003 together with a stall.
    dec_ready = 1'b0;
    step();
    chk_head("full_head", 32'h0000_2004);
    chk("full_addr", icache_addr, 32'h0000_200C);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3003;
    icache_stall   = 1'b1;
    step();
    redirect_valid = 1'b0;
    icache_stall   = 1'b0;
    dec_ready      = 1'b1;
    chk("redir3k_valid", 32'(dec_valid), 32'd0);
    chk("redir3k_addr", icache_addr, 32'h0000_3000);
    step();
    chk_head("f3k", 32'h0000_3000);

    // Back-to-back redirects, last wins; then wrap across 2^32.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_5000;
    step();
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    chk("b2b_valid", 32'(dec_valid), 32'd0);
    chk("b2b_addr", icache_addr, 32'hFFFF_FFFC);
    step();
    chk_head("wrap0", 32'hFFFF_FFFC);
    chk("wrap0_addr", icache_addr, 32'h0000_0000);
    step();
    chk_head("wrap1", 32'h0000_0000);
    chk("wrap1_addr", icache_addr, 32'h0000_0004);

    // Queue two entries, then assert reset between clock edges.
    dec_ready = 1'b0;
    step();
    chk_head("prerst", 32'h0000_0000);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(dec_valid), 32'd0);
    chk("arst_pc", dec_pc, 32'd0);
    chk("arst_instr", dec_instr, 32'd0);
    chk("arst_addr", icache_addr, 32'h0000_1000);
    dec_ready = 1'b1;
    #3;
    reset = 1'b0;
    chk("arst_rel_valid", 32'(dec_valid), 32'd0);
    step();
    chk_head("after_rst", 32'h0000_1000);
    chk("after_rst_addr", icache_addr, 32'h0000_1004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
